// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator and the code that drives it.
// Holds the initiator state encoding and the SPI master register byte offsets.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // SPI master register map (byte offsets)
    localparam logic [7:0] REG_STATUS = 8'h00;
    localparam logic [7:0] REG_CLKDIV = 8'h08;
    localparam logic [7:0] REG_SPICMD = 8'h10;
    localparam logic [7:0] REG_SPIADR = 8'h18;
    localparam logic [7:0] REG_SPILEN = 8'h20;
    localparam logic [7:0] REG_SPIDUM = 8'h28;
    localparam logic [7:0] REG_TXFIFO = 8'h30;
    localparam logic [7:0] REG_RXFIFO = 8'h38;

endpackage

// File: rtl/apb_master_if.sv
// APB initiator: converts one valid/ready request into an APB SETUP/ACCESS transfer
// and returns read data / error status on a valid/ready response channel.
module apb_master_if
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    input  logic                      req_write,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Handshakes: a beat transfers on a rising HCLK edge where valid and ready are both
    // high; a producer holds valid and its payload stable until that edge.

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    apb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic                      timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    pwrite_d  = req_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                // PREADY takes priority over an expiring timeout
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_if.sv
// Self-checking bench for apb_master_if: directed test-plan cases plus randomized
// transfers checked against a transaction-level reference model.
module tb_apb_master_if;
    import apb_master_pkg::*;

    localparam int AW = 12;
    localparam int TO = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];   // {timeout, err, rdata}

    apb_master_if #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a slave that answers after `waits` not-ready cycles either completes
    // normally or, if it would need more than TO access cycles, is aborted.
    function automatic logic [33:0] ref_rsp(input logic wr, input int waits,
                                            input logic slverr, input logic [31:0] prdata);
        if (waits >= TO) return {1'b1, 1'b1, 32'h0};
        return {1'b0, slverr, (wr ? 32'h0 : prdata)};
    endfunction

    function automatic int ref_access_len(input int waits);
        return (waits >= TO) ? TO : waits + 1;
    endfunction

    // Driver: one full transfer, request through response retirement. All driving and
    // sampling happens at the falling edge.
    task automatic run_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic wr, input int waits, input logic slverr,
                            input logic [31:0] prdata, input int hold);
        int acc;
        logic [33:0] exp, got;
        check_val("req_ready_idle", req_ready, 1'b1);
        exp_q.push_back(ref_rsp(wr, waits, slverr, prdata));
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_write = wr;
        PREADY = 1'b0;
        @(negedge HCLK);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
        check_val("setup_psel", PSEL, 1'b1);
        check_val("setup_penable", PENABLE, 1'b0);
        check_val("setup_busy", busy, 1'b1);
        @(negedge HCLK);
        check_val("access_pwrite", PWRITE, wr);
        if (wr) check_val("access_pwdata", PWDATA, wdata);
        acc = 0;
        while (PSEL && PENABLE && acc < 50) begin
            acc++;
            check_val("access_paddr", PADDR, addr);
            if (acc == waits + 1) begin
                PREADY = 1'b1; PRDATA = prdata; PSLVERR = slverr;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = $urandom;
            end
            @(negedge HCLK);
        end
        PREADY = 1'b0;
        check_val("access_len", acc, ref_access_len(waits));
        check_val("resp_psel", {PSEL, PENABLE}, 2'b00);
        check_val("resp_valid", rsp_valid, 1'b1);
        got = {rsp_timeout, rsp_err, rsp_rdata};
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            exp = exp_q.pop_front();
            check_val("resp_fields", got, exp);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge HCLK);
            check_val("hold_req_ready", req_ready, 1'b0);
            check_val("hold_fields", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, {1'b1, got});
            check_val("hold_paddr", PADDR, addr);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge HCLK);
        rsp_ready = 1'b0;
        check_val("retire_valid", rsp_valid, 1'b0);
        check_val("retire_busy", busy, 1'b0);
        check_val("retire_paddr", PADDR, addr);
    endtask

    initial begin
        logic [7:0] offs[8];
        int seen_rsp;
        offs = '{REG_STATUS, REG_CLKDIV, REG_SPICMD, REG_SPIADR,
                 REG_SPILEN, REG_SPIDUM, REG_TXFIFO, REG_RXFIFO};
        HRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(negedge HCLK);
        check_val("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
        check_val("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
        check_val("rst_busy", busy, 1'b0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // directed test-plan cases
        run_xfer(AW'(REG_CLKDIV), 32'h4, 1'b1, 0, 1'b0, 32'h1234_5678, 0);
        run_xfer(AW'(REG_RXFIFO), 32'h0, 1'b0, 3, 1'b0, 32'hDEAD_BEEF, 0);
        run_xfer(AW'(REG_STATUS), 32'h0, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 0);
        run_xfer(AW'(REG_SPICMD), 32'h55, 1'b0, 10, 1'b0, 32'hA5A5_A5A5, 0);
        run_xfer(AW'(REG_TXFIFO), 32'h77, 1'b1, 1, 1'b0, 32'h0, 5);
        run_xfer(AW'(REG_SPILEN), 32'h9, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1);

        // reset during ACCESS discards the transfer
        req_valid = 1'b1; req_addr = AW'(REG_SPIADR); req_wdata = 32'h11; req_write = 1'b0;
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        check_val("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_val("midrst_apb", {PSEL, PENABLE, PADDR}, '0);
        check_val("midrst_rsp", {rsp_valid, busy}, 2'b00);
        PREADY = 1'b1; rsp_ready = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            if (rsp_valid || busy) seen_rsp++;
        end
        PREADY = 1'b0; rsp_ready = 1'b0;
        check_val("midrst_no_rsp", seen_rsp, 0);

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            run_xfer(AW'(offs[$urandom_range(0, 7)]), $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 3));
        end
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
